cb_mul_seq: RTL and testbench

Sequential shift-add multiplier controller that time-shares the existing W-bit carry-out adder (the CB adder block) to produce a 2W-bit unsigned product. It accepts operand pairs over a valid/ready handshake and issues one adder operation per cycle. It returns the product over a second valid/ready handshake. It sits between an operand source and the adder instance; the parent wires `add_a`/`add_b` to the adder inputs and the adder's sum/carry back in.

---
 rtl/cb_mul_seq_pkg.sv | 18 +
 rtl/cb_mul_seq.sv | 134 +++++++++++++
 tb/tb_cb_mul_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_mul_seq_pkg.sv
// cb_mul_seq_pkg: shared definitions for the shift-add multiplier controller
// (FSM state encodings, default operand width, counter width helper).
package cb_mul_seq_pkg;

    localparam int unsigned CB_MUL_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_calc = 2'd1,
        st_done = 2'd2
    } cb_mul_state_t;

    // Step counter must be able to hold the value W itself.
    function automatic int unsigned cb_mul_cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cb_mul_seq.sv
// cb_mul_seq: sequential shift-add multiplier that time-shares an external
// W-bit carry-out adder, one adder operation per cycle, 2W-bit product.
// Optional feature: CB_MUL_EARLY_TERM_EN finishes as soon as the remaining
// multiplier bits are all zero.
module cb_mul_seq
    import cb_mul_seq_pkg::*;
#(
    parameter int unsigned W = CB_MUL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    input  logic [W-1:0]     add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*W-1:0]   res_prod,
    output logic             busy
);

    localparam int unsigned CNT_W = cb_mul_cnt_w(W);
    localparam int unsigned PW    = 2 * W;

    cb_mul_state_t      state;
    logic [PW-1:0]      p;
    logic [W-1:0]       mcand;
    logic [CNT_W-1:0]   cnt;

    logic [PW-1:0]      step_p;
    logic [CNT_W-1:0]   cnt_inc;
    logic               step_last;

`ifdef CB_MUL_EARLY_TERM_EN
    logic [W-1:0]       rem;
    logic [PW-1:0]      early_p;
`endif

    // One shift-add step: adder result becomes the new high half, multiplier bits shift down.
    always_comb begin
        step_p    = {add_cout, add_sum, p[W-1:1]};
        cnt_inc   = cnt + CNT_W'(1);
        step_last = (cnt_inc == CNT_W'(W));
`ifdef CB_MUL_EARLY_TERM_EN
        early_p   = p >> (CNT_W'(W) - cnt);
`endif
    end

    // Controller FSM, datapath registers and registered adder operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            p         <= '0;
            mcand     <= '0;
            cnt       <= '0;
            res_prod  <= '0;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
`ifdef CB_MUL_EARLY_TERM_EN
            rem       <= '0;
`endif
        end else begin
            case (state)
                st_idle: begin
                    if (op_valid) begin
                        state    <= st_calc;
                        mcand    <= op_a;
                        p        <= {W'(0), op_b};
                        cnt      <= '0;
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                        add_a    <= '0;
                        add_b    <= op_b[0] ? op_a : '0;
`ifdef CB_MUL_EARLY_TERM_EN
                        rem      <= op_b;
`endif
                    end
                end
                st_calc: begin
`ifdef CB_MUL_EARLY_TERM_EN
                    if (rem == '0) begin
                        state     <= st_done;
                        res_prod  <= early_p;
                        res_valid <= 1'b1;
                        add_a     <= '0;
                        add_b     <= '0;
                    end else
`endif
                    begin
                        p   <= step_p;
                        cnt <= cnt_inc;
`ifdef CB_MUL_EARLY_TERM_EN
                        rem <= rem >> 1;
`endif
                        if (step_last) begin
                            state     <= st_done;
                            res_prod  <= step_p;
                            res_valid <= 1'b1;
                            add_a     <= '0;
                            add_b     <= '0;
                        end else begin
                            add_a <= step_p[PW-1:W];
                            add_b <= step_p[0] ? mcand : '0;
                        end
                    end
                end
                st_done: begin
                    if (res_ready) begin
                        state     <= st_idle;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= st_idle;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    op_ready  <= 1'b1;
                    add_a     <= '0;
                    add_b     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cb_mul_seq.sv
// tb_cb_mul_seq: self-checking bench for cb_mul_seq with a transaction-level
// reference model and an ideal adder attached to the adder port pair.
module tb_cb_mul_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_prod;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // External carry-out adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    cb_mul_seq #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Accept-to-result latency from the multiplier's highest set bit.
    function automatic int exp_lat(input logic [W-1:0] b);
        int m;
        m = 0;
        for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
`ifdef CB_MUL_EARLY_TERM_EN
        if (m == W) return W;
        return m + 1;
`else
        return (m >= 0) ? W : W;
`endif
    endfunction

    // Reference model: 0 idle, 1 calculating, 2 result offered.
    int          m_st = 0;
    int          m_k = 0;
    int          m_left = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic [15:0] m_res = '0;
    logic        m_rq = 1'b0;
    bit          started = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1;
        m_rq    <= rst;
        if (rst) begin
            m_st  <= 0;
            m_res <= '0;
        end else begin
            case (m_st)
                0: if (op_valid) begin
                    m_a    <= {8'd0, op_a};
                    m_b    <= {8'd0, op_b};
                    m_k    <= 0;
                    m_left <= exp_lat(op_b);
                    m_st   <= 1;
                end
                1: begin
                    m_k    <= m_k + 1;
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_st  <= 2;
                        m_res <= m_a * m_b;
                    end
                end
                default: if (res_ready) m_st <= 0;
            endcase
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin : cmp
        logic [15:0] msk;
        logic [15:0] ea;
        logic [15:0] eb;
        if (started) begin
            chk("op_ready", op_ready, m_st == 0);
            chk("busy", busy, m_st != 0);
            chk("res_valid", res_valid, m_st == 2);
            if (m_st == 2 || m_rq) chk("res_prod", res_prod, m_res);
            if (m_st == 1) begin
                msk = (16'd1 << m_k) - 16'd1;
                ea  = (m_a * (m_b & msk)) >> m_k;
                eb  = m_b[m_k] ? m_a : 16'd0;
            end else begin
                ea = '0;
                eb = '0;
            end
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
        end
    end

    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (op_ready) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit pulse, input int elat, input int eprod);
        bit ok;
        int lat;
        op_a = a; op_b = b; op_valid = 1'b1; res_ready = (hold == 0);
        wait_accept(ok);
        op_valid = 1'b0;
        if (!ok) return;
        ok = 0; lat = 0;
        while (lat < 40 && !ok) begin
            @(posedge clk); #1;
            lat++;
            op_valid = pulse && (lat == 2);
            if (pulse && lat == 2) begin op_a = 8'd7; op_b = 8'd7; end
            if (res_valid) ok = 1;
        end
        op_valid = 1'b0;
        chk("latency", lat, elat);
        chk("product", res_prod, eprod);
        repeat (hold) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_take", op_ready, 1);
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; int lb; int le; int p; } vec_t;
    vec_t tbl[9] = '{
        '{8'd1,   8'd6,   8, 4, 6},
        '{8'd1,   8'd100, 8, 8, 100},
        '{8'd5,   8'd10,  8, 5, 50},
        '{8'd100, 8'd127, 8, 8, 12700},
        '{8'd127, 8'd127, 8, 8, 16129},
        '{8'd255, 8'd255, 8, 8, 65025},
        '{8'd200, 8'd0,   8, 1, 0},
        '{8'd9,   8'd6,   8, 4, 54},
        '{8'd3,   8'd128, 8, 8, 384}
    };

    initial begin : stim
        bit ok;
        int prev_cyc;
        logic [7:0] prev_b;
        rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_prod", res_prod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
`ifdef CB_MUL_EARLY_TERM_EN
            do_mul(tbl[i].a, tbl[i].b, 0, 0, tbl[i].le, tbl[i].p);
`else
            do_mul(tbl[i].a, tbl[i].b, 0, 0, tbl[i].lb, tbl[i].p);
`endif
        end

        // Backpressure with a dropped op_valid pulse during calculation.
        do_mul(8'd5, 8'd100, 4, 1, 8, 500);
        repeat (12) @(posedge clk);
        #1;

        // Reset in the third calculation cycle of 100x100.
        op_a = 8'd100; op_b = 8'd100; op_valid = 1'b1;
        wait_accept(ok);
        op_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_op_ready", op_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_prod", res_prod, 0);
        chk("midrst_add_a", add_a, 0);
        chk("midrst_add_b", add_b, 0);
`ifdef CB_MUL_EARLY_TERM_EN
        do_mul(8'd1, 8'd6, 0, 0, 4, 6);
`else
        do_mul(8'd1, 8'd6, 0, 0, 8, 6);
`endif

        // Back-to-back random stream with op_valid held high.
        res_ready = 1'b1;
        op_valid  = 1'b1;
        prev_cyc  = 0;
        prev_b    = '0;
        for (int i = 0; i < 20; i++) begin
            op_a = 8'($urandom_range(0, 255));
            op_b = 8'($urandom_range(0, 255));
            wait_accept(ok);
            if (i > 0) chk("issue_interval", cyc - prev_cyc, exp_lat(prev_b) + 2);
            prev_cyc = cyc;
            prev_b   = op_b;
        end
        op_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
